// File: rtl/traffic_pkg.sv
// Shared phase encoding and duration helpers for the phase timer and the light FSM.
package traffic_pkg;

  typedef enum logic [3:0] {
    PH_A = 4'd0,
    PH_B = 4'd1,
    PH_C = 4'd2,
    PH_D = 4'd3,
    PH_E = 4'd4,
    PH_F = 4'd5
  } phase_t;

  function automatic phase_t next_phase(input phase_t p);
    phase_t n;
    case (p)
      PH_A:    n = PH_B;
      PH_B:    n = PH_C;
      PH_C:    n = PH_D;
      PH_D:    n = PH_E;
      PH_E:    n = PH_F;
      default: n = PH_A;
    endcase
    return n;
  endfunction

  // A zero duration would never reach remaining==1, so it is promoted to one tick.
  function automatic logic [7:0] sat_ticks(input int unsigned t);
    logic [7:0] r;
    if (t == 0)        r = 8'd1;
    else if (t > 255)  r = 8'd255;
    else               r = t[7:0];
    return r;
  endfunction

  function automatic logic [7:0] phase_duration(input phase_t p,
                                                input logic [7:0] walk,
                                                input logic [7:0] clear,
                                                input logic [7:0] yellow);
    logic [7:0] d;
    case (p)
      PH_A, PH_D: d = walk;
      PH_B, PH_E: d = clear;
      default:    d = yellow;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/req_sync.sv
// Two-flop synchroniser for a raw push-button plus a one-cycle rising-edge pulse.
module req_sync (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic meta;
  logic stable;
  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= raw;
      stable <= meta;
      prev   <= stable;
    end
  end

  assign pulse = stable & ~prev;

endmodule

// File: rtl/phase_timer.sv
// Phase sequencer driving the traffic-light FSM's change input, with pedestrian request clamping.
// Optional clearance blink on ped_blink is built only when PHASE_TIMER_BLINK_EN is defined.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned WALK_T   = 20,
  parameter int unsigned CLEAR_T  = 5,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned REQ_GAP  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       ped_req1,
  input  logic       ped_req2,
  output logic       change,
  output logic [3:0] phase,
  output logic [7:0] remaining,
  output logic       pending1,
  output logic       pending2,
  output logic       ped_blink
);

  localparam int unsigned DIV = (TICK_DIV == 0) ? 1 : TICK_DIV;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  localparam logic [7:0] WALK   = sat_ticks(WALK_T);
  localparam logic [7:0] CLEAR  = sat_ticks(CLEAR_T);
  localparam logic [7:0] YELLOW = sat_ticks(YELLOW_T);
  localparam logic [7:0] GAP    = sat_ticks(REQ_GAP);

  logic [CW-1:0] count_q, count_d;
  phase_t        phase_q, phase_d, nxt;
  logic [7:0]    rem_q, rem_d, dec;
  logic          change_d;
  logic          p1_q, p1_d, p2_q, p2_d;
  logic          tick, advance, clamp_en;
  logic          pulse1, pulse2;

  req_sync u_sync1 (
    .clock (clock),
    .reset (reset),
    .raw   (ped_req1),
    .pulse (pulse1)
  );

  req_sync u_sync2 (
    .clock (clock),
    .reset (reset),
    .raw   (ped_req2),
    .pulse (pulse2)
  );

  always_comb begin
    tick     = run && (count_q == LAST);
    count_d  = count_q;
    if (run) count_d = tick ? '0 : count_q + 1'b1;

    advance  = tick && (rem_q == 8'd1);
    nxt      = next_phase(phase_q);
    dec      = tick ? rem_q - 8'd1 : rem_q;
    clamp_en = ((phase_q == PH_A) && p1_q) || ((phase_q == PH_D) && p2_q);

    phase_d  = phase_q;
    rem_d    = dec;
    change_d = 1'b0;
    // Transition outranks clamp; clamp only ever shortens the post-decrement value.
    if (advance) begin
      phase_d  = nxt;
      rem_d    = phase_duration(nxt, WALK, CLEAR, YELLOW);
      change_d = 1'b1;
    end else if (clamp_en && (dec > GAP)) begin
      rem_d    = GAP;
    end

    // Clearing on the serving transition wins over a simultaneous new press.
    p1_d = (advance && (nxt == PH_D)) ? 1'b0 : (p1_q | pulse1);
    p2_d = (advance && (nxt == PH_A)) ? 1'b0 : (p2_q | pulse2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      phase_q  <= PH_A;
      rem_q    <= WALK;
      change   <= 1'b0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      phase_q  <= phase_d;
      rem_q    <= rem_d;
      change   <= change_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

`ifdef PHASE_TIMER_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (tick) begin
      if (advance)                                   blink_d = 1'b0;
      else if ((phase_q == PH_B) || (phase_q == PH_E)) blink_d = ~blink_q;
      else                                           blink_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) blink_q <= 1'b0;
    else       blink_q <= blink_d;
  end

  assign ped_blink = blink_q;
`else
  assign ped_blink = 1'b0;
`endif

  assign phase     = phase_q;
  assign remaining = rem_q;
  assign pending1  = p1_q;
  assign pending2  = p2_q;

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer: pulse-schedule table, hand corner sequences, random run vs reference model.
module tb_phase_timer;

  localparam int TDIV = 4;
  localparam int WALK = 6;
  localparam int CLR  = 2;
  localparam int YEL  = 1;
  localparam int GAP  = 2;
`ifdef PHASE_TIMER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic       ped_req1;
  logic       ped_req2;
  logic       change;
  logic [3:0] phase;
  logic [7:0] remaining;
  logic       pending1;
  logic       pending2;
  logic       ped_blink;

  phase_timer #(
    .TICK_DIV (TDIV),
    .WALK_T   (WALK),
    .CLEAR_T  (CLR),
    .YELLOW_T (YEL),
    .REQ_GAP  (GAP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .ped_req1  (ped_req1),
    .ped_req2  (ped_req2),
    .change    (change),
    .phase     (phase),
    .remaining (remaining),
    .pending1  (pending1),
    .pending2  (pending2),
    .ped_blink (ped_blink)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int edge_no = 0;

  // Reference model: tick counter, phase index into a duration table, request history.
  int m_cnt, m_ph, m_rem;
  bit m_p1, m_p2, m_blink, m_change;
  bit h1[3];
  bit h2[3];
  int dur[6] = '{WALK, CLR, YEL, WALK, CLR, YEL};

  typedef struct {
    int edge_n;
    bit ch;
    int ph;
    int rem;
    bit blink;
  } vec_t;

  vec_t vec[13];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_rem = WALK;
    m_p1 = 0; m_p2 = 0; m_blink = 0; m_change = 0;
    for (int i = 0; i < 3; i++) begin h1[i] = 0; h2[i] = 0; end
  endtask

  task automatic model_step(input bit r, input bit q1, input bit q2);
    bit press1, press2, tk, adv, clampable;
    press1 = h1[1] && !h1[2];
    press2 = h2[1] && !h2[2];
    h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = q1;
    h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = q2;
    tk = r && (m_cnt == TDIV - 1);
    adv = tk && (m_rem == 1);
    clampable = (m_ph == 0 && m_p1) || (m_ph == 3 && m_p2);
    if (adv) begin
      m_ph = (m_ph + 1) % 6;
      m_rem = dur[m_ph];
      m_change = 1;
    end else begin
      m_change = 0;
      if (tk) m_rem = m_rem - 1;
      if (clampable && m_rem > GAP) m_rem = GAP;
    end
    m_p1 = (adv && m_ph == 3) ? 1'b0 : (m_p1 || press1);
    m_p2 = (adv && m_ph == 0) ? 1'b0 : (m_p2 || press2);
    if (BLINK && tk) m_blink = adv ? 1'b0 : ((m_ph == 1 || m_ph == 4) ? !m_blink : 1'b0);
    if (r) m_cnt = (m_cnt + 1) % TDIV;
  endtask

  task automatic check_model();
    check("change",    change,    m_change);
    check("phase",     phase,     m_ph);
    check("remaining", remaining, m_rem);
    check("pending1",  pending1,  m_p1);
    check("pending2",  pending2,  m_p2);
    check("ped_blink", ped_blink, m_blink);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_change"},    change,    0);
    check({tag, "_phase"},     phase,     0);
    check({tag, "_remaining"}, remaining, WALK);
    check({tag, "_pending1"},  pending1,  0);
    check({tag, "_pending2"},  pending2,  0);
    check({tag, "_ped_blink"}, ped_blink, 0);
  endtask

  task automatic cyc(input bit r, input bit q1, input bit q2);
    run = r; ped_req1 = q1; ped_req2 = q2;
    @(posedge clock);
    model_step(r, q1, q2);
    edge_no++;
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; ped_req1 = 1'b0; ped_req2 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_vals("reset_hold");
    reset = 1'b0;
    model_reset();
    edge_no = 0;
  endtask

  initial begin
    int found;
    bit r1, r2;

    vec = '{
      '{4,  1'b0, 0, 5, 1'b0},
      '{23, 1'b0, 0, 1, 1'b0},
      '{24, 1'b1, 1, 2, 1'b0},
      '{25, 1'b0, 1, 2, 1'b0},
      '{28, 1'b0, 1, 1, BLINK},
      '{32, 1'b1, 2, 1, 1'b0},
      '{33, 1'b0, 2, 1, 1'b0},
      '{36, 1'b1, 3, 6, 1'b0},
      '{60, 1'b1, 4, 2, 1'b0},
      '{64, 1'b0, 4, 1, BLINK},
      '{68, 1'b1, 5, 1, 1'b0},
      '{72, 1'b1, 0, 6, 1'b0},
      '{73, 1'b0, 0, 6, 1'b0}
    };

    reset = 1'b1; run = 1'b0; ped_req1 = 1'b0; ped_req2 = 1'b0;
    #3;
    check_reset_vals("por");
    do_reset();

    // Full cycle schedule from reset release
    for (int i = 0; i < 13; i++) begin
      while (edge_no < vec[i].edge_n) cyc(1'b1, 1'b0, 1'b0);
      check($sformatf("tbl%0d_change", i), change, vec[i].ch);
      check($sformatf("tbl%0d_phase", i), phase, vec[i].ph);
      check($sformatf("tbl%0d_remaining", i), remaining, vec[i].rem);
      check($sformatf("tbl%0d_blink", i), ped_blink, vec[i].blink);
    end

    // Freeze for 10 cycles in phase A delays the first change by exactly 10
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
    check("freeze_rem_before", remaining, 4);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
    check("freeze_rem_after", remaining, 4);
    found = -1;
    for (int i = 0; i < 100 && found < 0; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (change) found = edge_no;
    end
    check("freeze_change_edge", found, 34);

    // Held request 1 in A clamps the walk and clears on entry to D
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
    check("clamp_start_rem", remaining, 5);
    while (edge_no < 30) begin
      cyc(1'b1, edge_no < 24, 1'b0);
      if (edge_no == 6)  check("clamp_pend_early", pending1, 0);
      if (edge_no == 7)  check("clamp_pend_set", pending1, 1);
      if (edge_no == 8)  check("clamp_rem", remaining, 2);
      if (edge_no == 16) check("clamp_a_end", {change, phase}, {1'b1, 4'd1});
      if (edge_no == 27) check("clamp_pend_hold", pending1, 1);
      if (edge_no == 28) check("clamp_pend_clr", {pending1, phase}, {1'b0, 4'd3});
    end

    // Request 2 during B: no clamp in B/C, D clamped, clears entering A
    do_reset();
    while (edge_no < 60) begin
      cyc(1'b1, 1'b0, (edge_no >= 24 && edge_no < 27));
      if (edge_no == 27) check("req2_set", pending2, 1);
      if (edge_no == 32) check("req2_no_clamp_b", {change, phase}, {1'b1, 4'd2});
      if (edge_no == 37) check("req2_clamp_d", remaining, 2);
      if (edge_no == 44) check("req2_d_end", {change, phase}, {1'b1, 4'd4});
      if (edge_no == 55) check("req2_pend_hold", pending2, 1);
      if (edge_no == 56) check("req2_pend_clr", {pending2, phase}, {1'b0, 4'd0});
    end

    // Request 1 press lands on the C->D edge: counts as served
    do_reset();
    while (edge_no < 62) begin
      cyc(1'b1, (edge_no >= 33 && edge_no < 40), 1'b0);
      if (edge_no == 36) check("same_cycle_clr", {pending1, phase}, {1'b0, 4'd3});
      if (edge_no == 37) check("same_cycle_stay", pending1, 0);
      if (edge_no == 60) check("same_cycle_full_d", {change, phase}, {1'b1, 4'd4});
    end

    // Asynchronous reset mid-phase E
    check("pre_reset_phase", phase, 4);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    @(negedge clock);
    @(posedge clock);
    #1;
    check("async_no_change", change, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    edge_no = 0;

    // Random run/request stimulus against the model
    r1 = 0; r2 = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) r1 = !r1;
      if ($urandom_range(0, 11) == 0) r2 = !r2;
      cyc($urandom_range(0, 7) != 0, r1, r2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
